regfile_gen: RTL
================

# regfile_gen

Parametrised general-purpose register file for the single-cycle CPU datapath, succeeding the fixed 32x32 register file. It has configurable data width and depth, an optional hardwired-zero register 0, and byte-enabled writes. An optional write-to-read bypass is provided. A sequential soft-clear engine zeroes the array one entry per cycle, with a ready handshake on the write port.

## Interface
- DATA_W, 32, register width in bits; must be a multiple of 8
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- ZERO_REG, 1, 1: entry 0 reads as 0 and ignores writes
- BYPASS, 1, 1: an accepted write is visible on a same-cycle read of the same address
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- we  input  1  write request
- wready  output  1  write port can accept; a write occurs only when we && wready
- waddr  input  ADDR_W  write address
- wbe  input  DATA_W/8  byte enables; bit i covers wdata[8i+7:8i]
- wdata  input  DATA_W  write data
- raddr1, raddr2  input  ADDR_W  read addresses
- rdata1, rdata2  output  DATA_W  combinational read data
- clr_req  input  1  soft-clear request, sampled only in IDLE
- clr_busy  output  1  soft-clear in progress

## Operation
- Storage: DEPTH x DATA_W flops. On an accepted write, byte i of entry waddr is replaced by wdata byte i where wbe[i]=1. Bytes with wbe[i]=0 are unchanged.
- ZERO_REG=1:
  - Writes to address 0 are dropped.
  - rdata for raddr=0 is 0 regardless of BYPASS.
- Reads are combinational: rdataN = entry[raddrN].
- BYPASS=1: if we && wready && waddr==raddrN (and not the ZERO_REG=1 / address 0 case), rdataN = byte-merged value (new bytes where wbe=1, stored bytes elsewhere).
- BYPASS=0: reads return the stored value until the next edge.
- Soft-clear FSM has two states: IDLE and CLEAR. Counter cnt is ADDR_W bits wide.
  - IDLE, clr_req=1: go to CLEAR, cnt<=0.
  - CLEAR: entry[cnt] <= 0 every cycle, cnt<=cnt+1. When cnt==DEPTH-1, clear that entry and return to IDLE. cnt wraps to 0.
  - clr_req is ignored in CLEAR; it is not queued.
- Outputs: wready = (state==IDLE); clr_busy = (state==CLEAR).
- Writes presented while wready=0 are dropped silently. The master must hold we until it sees wready.
- Reads are always serviced during CLEAR:
  - entries with index < cnt read 0;
  - the entry being cleared this cycle still shows its old value;
  - entries not yet reached keep their old values.

## Timing
- Reset state: all entries 0, state IDLE, cnt 0, wready=1, clr_busy=0.
- rst has priority over everything, including an in-flight CLEAR. The cycle after rst, the FSM is in IDLE and all entries are 0.
- Write latency: data is visible on the next cycle (same cycle with BYPASS=1).
- Soft-clear timing:
  - clr_busy rises 1 cycle after clr_req is sampled.
  - clr_busy stays high for exactly DEPTH cycles.
  - wready returns to 1 on the cycle after the final entry is cleared.
- Simultaneous we and clr_req in IDLE: the write is accepted that edge, and the clear starts the next cycle and erases it.
- Simultaneous rst and clr_req: reset wins; the FSM stays in IDLE.
- No bypass of clear zeroes: a read during the cycle entry k is cleared returns its old value.

## Structure
- Shared package regfile_pkg:
  - FSM state enum (ST_IDLE, ST_CLEAR);
  - byte-lane count helper NBYTES = DATA_W/8.
- One sub-module, regfile_rd_port, is instantiated twice. It implements the address mux, zero-register forcing and the bypass merge.
- Clear FSM, counter and storage live in the top module regfile_gen.

## Test plan
- Reset:
  - rst=1 for 2 cycles, then read all addresses;
  - expect 0 everywhere, wready=1, clr_busy=0.
- Byte-enabled write:
  - write 0xAABBCCDD to r5 with wbe=4'b1111;
  - next cycle write 0x11223344 with wbe=4'b0101;
  - rdata1(r5) = 0xAA22CC44.
- Bypass (BYPASS=1):
  - write 0xDEADBEEF to r7 with raddr2=7 in the same cycle;
  - rdata2 = 0xDEADBEEF combinationally.
  - With BYPASS=0 the same stimulus returns the old r7 value.
- Zero register:
  - write 0xFFFFFFFF to r0;
  - rdata1(r0)=0 in the same cycle and the next.
  - With ZERO_REG=0 the next-cycle read is 0xFFFFFFFF.
- Soft clear:
  - fill r1..r31 with their index;
  - pulse clr_req;
  - clr_busy is high for exactly 32 cycles and wready is low for the same cycles;
  - a write to r3 issued mid-clear is dropped;
  - afterwards all entries read 0.
- Reset mid-clear:
  - assert rst 10 cycles into CLEAR;
  - next cycle state is IDLE, clr_busy=0, wready=1, all entries 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and helpers for the parametrised register file
package regfile_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    function automatic int nbytes(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// rtl/regfile_rd_port.sv - one combinational read port: address mux, zero forcing, bypass merge
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic [(2**ADDR_W)-1:0][DATA_W-1:0] mem,
    input  logic [ADDR_W-1:0]                  raddr,
    input  logic                               wr_fire,
    input  logic [ADDR_W-1:0]                  waddr,
    input  logic [DATA_W/8-1:0]                wbe,
    input  logic [DATA_W-1:0]                  wdata,
    output logic [DATA_W-1:0]                  rdata
);

    localparam int NB = nbytes(DATA_W);

    always_comb begin
        rdata = mem[raddr];
        if (BYPASS != 0 && wr_fire && waddr == raddr) begin
            for (int i = 0; i < NB; i++) begin
                if (wbe[i]) begin
                    rdata[8*i +: 8] = wdata[8*i +: 8];
                end
            end
        end
        // Zero forcing last so it also masks a bypassed write to entry 0.
        if (ZERO_REG != 0 && raddr == '0) begin
            rdata = '0;
        end
    end

endmodule

// File: rtl/regfile_gen.sv
// rtl/regfile_gen.sv - parametrised register file with byte-enabled writes and sequential soft clear
module regfile_gen
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    output logic                wready,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [DATA_W/8-1:0] wbe,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [ADDR_W-1:0]   raddr1,
    input  logic [ADDR_W-1:0]   raddr2,
    output logic [DATA_W-1:0]   rdata1,
    output logic [DATA_W-1:0]   rdata2,
    input  logic                clr_req,
    output logic                clr_busy
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int NB    = nbytes(DATA_W);

    logic [DEPTH-1:0][DATA_W-1:0] mem;
    state_e                       state;
    logic [ADDR_W-1:0]            cnt;
    logic                         wr_fire;
    logic                         wr_drop;

    assign wready   = (state == ST_IDLE);
    assign clr_busy = (state == ST_CLEAR);
    assign wr_fire  = we && wready;
    assign wr_drop  = (ZERO_REG != 0) && (waddr == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            mem   <= '0;
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (wr_fire && !wr_drop) begin
                        for (int i = 0; i < NB; i++) begin
                            if (wbe[i]) begin
                                mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                            end
                        end
                    end
                    // A write in the same cycle lands first and is then erased by the clear.
                    if (clr_req) begin
                        state <= ST_CLEAR;
                        cnt   <= '0;
                    end
                end
                ST_CLEAR: begin
                    mem[cnt] <= '0;
                    cnt      <= cnt + 1'b1;
                    if (cnt == ADDR_W'(DEPTH - 1)) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    regfile_rd_port #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .ZERO_REG(ZERO_REG),
        .BYPASS  (BYPASS)
    ) u_rd1 (
        .mem    (mem),
        .raddr  (raddr1),
        .wr_fire(wr_fire),
        .waddr  (waddr),
        .wbe    (wbe),
        .wdata  (wdata),
        .rdata  (rdata1)
    );

    regfile_rd_port #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .ZERO_REG(ZERO_REG),
        .BYPASS  (BYPASS)
    ) u_rd2 (
        .mem    (mem),
        .raddr  (raddr2),
        .wr_fire(wr_fire),
        .waddr  (waddr),
        .wbe    (wbe),
        .wdata  (wdata),
        .rdata  (rdata2)
    );

endmodule
